// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err_o.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rxd_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overrun_o,
    output logic                          frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err_o,
`endif
    input  logic                          clr_err_i,
    output logic                          busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx1_q, rxs_q;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovr_q, ovr_d, ferr_q, ferr_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic            tick, push, ferr_set, pop, full, wr, ovr_set;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d, pbad_q, pbad_d, perr_set;
`endif

    assign tick    = cnt_q == 16'd0;
    assign valid_o = count_q != '0;
    assign full    = count_q == CW'(FIFO_DEPTH);
    assign pop     = valid_o && ready_i;
    assign wr      = push && (!full || pop);
    assign ovr_set = push && full && !pop;
    assign data_o  = valid_o ? mem[rptr_q] : 8'h00;
    assign count_o = count_q;
    assign overrun_o   = ovr_q;
    assign frame_err_o = ferr_q;
    assign busy_o  = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

    // Receiver FSM: mid-bit sampling driven by the baud down-counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q != IDLE && !tick) ? cnt_q - 16'd1 : cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d   = pbad_q;
        perr_set = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rxs_q) begin
                state_d = START;
                cnt_d   = HALF;
            end
            START: if (tick) begin
                state_d = rxs_q ? IDLE : DATA;
                cnt_d   = FULL;
                idx_d   = 3'd0;
            end
            DATA: if (tick) begin
                shift_d[idx_q] = rxs_q;
                cnt_d          = FULL;
                idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx_q == 3'd7) state_d = PARITY;
`else
                if (idx_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                perr_set = ^shift_q ^ rxs_q;
                pbad_d   = perr_set;
                cnt_d    = FULL;
                state_d  = STOP;
            end
`endif
            STOP: if (tick) begin
                state_d  = IDLE;
`ifdef UART_RX_PARITY_EN
                push     = rxs_q && !pbad_q;
`else
                push     = rxs_q;
`endif
                ferr_set = !rxs_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer/occupancy and sticky error flag next-state
    always_comb begin
        wptr_d  = wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(wr) - CW'(pop);
        ovr_d   = ovr_set | (ovr_q & !clr_err_i);
        ferr_d  = ferr_set | (ferr_q & !clr_err_i);
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_set | (perr_q & !clr_err_i);
`endif
    end

    // State registers; synchronizer resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx1_q   <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            rx1_q   <= rxd_i;
            rxs_q   <= rx1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    // FIFO storage; contents are only observable through valid_o so no reset is needed
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr) mem[wptr_q] <= shift_q;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a receive FIFO; the receiving end of the serial line whose idle-high `rxd` the simulation top drives into the SoC.
- Attaches to the dbus MMIO decoder: the CPU polls `valid_o`, reads `data_o`, and pops with `ready_i`.
- Lets the bench inject characters into firmware running on the core, complementing the existing dbus write/`txd` output path.

Parameters:
- CLKS_PER_BIT, 868, `clk_i` cycles per bit (100 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, at least 2.

Ports:
- clk_i  input  1  system clock; all logic on posedge.
- rst_i  input  1  synchronous reset, active-high.
- rxd_i  input  1  serial input, idle high, asynchronous to `clk_i`.
- data_o  output  8  byte at the FIFO head.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  pop strobe; pops when `valid_o` and `ready_i` are both high.
- count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun_o  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err_o  output  1  sticky: the stop bit was sampled low.
- clr_err_i  input  1  clears both sticky flags.
- busy_o  output  1  receiver FSM is not in IDLE.

Behaviour:
- Reset (`rst_i` high at a posedge):
  - FSM goes to IDLE; FIFO pointers and count cleared.
  - `valid_o`=0, `count_o`=0, `overrun_o`=0, `frame_err_o`=0, `busy_o`=0, `data_o`=0.
  - Synchronizer flops are set to 1 (idle).
  - Reset mid-frame abandons the frame; no partial byte is ever written.
- Input sync: `rxd_i` passes through a 2-FF synchronizer; `rxs` is its output. All sampling uses `rxs`.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: on `rxs`=0, go to START and load the baud counter with CLKS_PER_BIT/2 - 1.
  - START: when the counter hits 0 (mid start bit), resample `rxs`.
    - If `rxs`=1: glitch; return to IDLE with no flags set.
    - If `rxs`=0: go to DATA, load counter with CLKS_PER_BIT-1, bit index = 0.
  - DATA: each counter expiry samples `rxs` into `shift[idx]`, LSB first, and reloads CLKS_PER_BIT-1. After idx 7, go to STOP.
  - STOP: at counter expiry:
    - `rxs`=1: push `shift` into the FIFO.
    - `rxs`=0: set `frame_err_o` and discard the byte.
    - Either way go to IDLE. The next start edge is accepted from the following cycle.
- Latency: the byte is visible on `data_o`/`valid_o` one cycle after the mid-stop-bit sample. That is about 9.5×CLKS_PER_BIT+3 cycles after the `rxd_i` falling edge.
- FIFO:
  - First-word-fall-through; `data_o` = head entry and is valid whenever `valid_o` is high.
  - Push and pop in the same cycle: both take effect, `count_o` unchanged. Allowed even when full.
  - Push while full without a pop: byte dropped, `overrun_o` set, FIFO contents unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. `count_o` ranges 0..FIFO_DEPTH.
- Sticky flags:
  - `clr_err_i` clears both flags.
  - An error event in the same cycle as `clr_err_i` wins: the flag stays 1.
- `busy_o` = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples one bit.
  - If (^shift ^ sampled) = 1, set sticky `parity_err_o` and discard the byte.
  - `parity_err_o` (output, 1 bit) exists only under the macro; reset 0, cleared by `clr_err_i`.
- Undefined: no PARITY state, no `parity_err_o` port; frame is 8N1.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated):
- Single byte: send 0xA5 8N1, then `rxd_i` idle → `valid_o` rises once, `data_o`=0xA5, `count_o`=1. Pulse `ready_i` → `valid_o`=0, `count_o`=0. No flags.
- Back-to-back bytes: send 0x00, 0xFF, 0x55, 0x3C with no gap between frames → FIFO full, `count_o`=4; pops return bytes in order.
- Overrun: fill 4 bytes, send a 5th (0x77) without popping → `overrun_o`=1, head still 0x00, `count_o`=4. `clr_err_i` pulse → `overrun_o`=0.
- Framing error: send 0x12 with stop bit held 0 → `frame_err_o`=1, `count_o` unchanged. A following valid 0x34 is received correctly.
- Glitch and reset:
  - 1-cycle low pulse on `rxd_i` → FSM returns to IDLE, nothing pushed.
  - Assert `rst_i` during DATA of 0x99 → `busy_o`=0, `count_o`=0. A subsequent 0x42 is received intact.
- Simultaneous push/pop with the FIFO full: pop asserted in the same cycle as the 5th byte's push → no overrun, `count_o`=4. Bytes 2 to 5 are read out in order.
